uart_cmd_decoder: RTL
=====================

UART_CMD_DECODER -- requirements
Module: uart_cmd_decoder

Interface
REQ-001 Parameter TIMEOUT_CYC, default 100_000_000, is the number of idle cycles before a partial set command is aborted (1 s at 100 MHz).
REQ-002 clk  in  1  system clock; all logic is on its rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 rdata  in  8  RX FIFO head byte; valid whenever empty=0 (first-word fall-through).
REQ-005 empty  in  1  RX FIFO empty flag.
REQ-006 pop  out  1  RX FIFO pop; one cycle per consumed byte.
REQ-007 run_toggle  out  1  one-cycle pulse: stopwatch run/stop.
REQ-008 clear  out  1  one-cycle pulse: stopwatch clear.
REQ-009 mode_toggle  out  1  one-cycle pulse: watch/stopwatch display select.
REQ-010 set_valid  out  1  one-cycle pulse: set_hour, set_min and set_sec are newly loaded.
REQ-011 set_hour  out  5  binary hour, 0..23, held until the next set_valid.
REQ-012 set_min  out  6  binary minute, 0..59, held.
REQ-013 set_sec  out  6  binary second, 0..59, held.
REQ-014 err  out  1  one-cycle pulse: rejected byte, rejected value or timeout.
REQ-015 busy  out  1  high while the state is SET or CHECK.

Function
REQ-016 States: IDLE, SET, CHECK; a 3-bit digit counter dcnt (0..5) is used in SET.
REQ-017 pop SHALL be ~empty in IDLE and SET, and 0 in CHECK and during reset; at most one byte is consumed per cycle, sampled in the pop cycle.
REQ-018 In IDLE, byte commands are case-insensitive:
- 'R' -> run_toggle
- 'C' -> clear
- 'M' -> mode_toggle
- 'T' -> go to SET with dcnt=0
- CR (0x0D), LF (0x0A) and space -> ignored, no pulse
- any other byte -> err
REQ-019 Output pulses are registered and assert exactly in the cycle after the pop cycle.
REQ-020 In SET, a byte '0'..'9' is stored as a 4-bit digit at index dcnt; dcnt increments; the 6th digit moves the state to CHECK.
REQ-021 In SET, any non-digit byte (including 'T', CR and LF) SHALL pulse err, discard the stored digits and return to IDLE.
REQ-022 CHECK lasts one cycle and computes each field as tens*10+ones; the products are formed at 7-bit width and truncated to the field width.
REQ-023 CHECK outcome:
- all of HH<=23, MM<=59 and SS<=59 -> load set_* and pulse set_valid
- otherwise -> pulse err and leave set_* unchanged
- in both cases the next state is IDLE
REQ-024 Latency: 6th digit popped at cycle N -> CHECK at N+1 -> set_valid or err at N+2; first pop possible again at N+2.
REQ-025 Back-to-back commands with empty held low SHALL be consumed one per cycle with no byte lost.

Reset
REQ-026 While rst=1 or after an asynchronous assertion, the following SHALL hold: state=IDLE, dcnt=0, stored digits=0, all pulse outputs=0, pop=0, busy=0, and set_hour/set_min/set_sec=0.
REQ-027 A reset during SET or CHECK SHALL abort the command with no set_valid and no err pulse.

Configuration
REQ-028 Macro UART_CMD_TIMEOUT_EN:
- Defined: a counter clears on each consumed byte and counts cycles spent in SET; reaching TIMEOUT_CYC-1 pulses err and returns to IDLE with the digits discarded.
- Undefined: the counter is absent and SET waits indefinitely.

Structure
REQ-029 Package uart_cmd_pkg SHALL hold:
- the state typedef
- ASCII constants for R, C, M, T, CR, LF, space, '0' and '9'
- limits HOUR_MAX=23 and MIN_SEC_MAX=59
- SET_DIGITS=6
REQ-030 Sub-module uart_cmd_bcd2bin SHALL be instantiated three times; it takes two 4-bit digits and produces a 7-bit binary value.

Verification
REQ-031 Bench scenarios:
- FIFO holds "r" -> one pop, then run_toggle=1 for exactly one cycle, no err.
- FIFO holds "T123456", empty low throughout -> 7 consecutive pops, one CHECK cycle, then set_valid with hour=12, min=34, sec=56.
- FIFO holds "T245959" -> err pulse and set_* retains previous values; "T235960" -> err.
- FIFO holds "T12x" -> err one cycle after 'x' is popped, state IDLE; a following "c" -> clear pulse.
- With UART_CMD_TIMEOUT_EN and TIMEOUT_CYC=16: FIFO holds "T12" then stays empty -> err 16 cycles after the '2' pop, busy falls.
- rst asserted mid-"T1234" -> all outputs 0 immediately, no err; after release, "m" -> mode_toggle pulse.

Source files
------------

// File: rtl/uart_cmd_pkg.sv
// ============================================================================
// Module   : uart_cmd_pkg
// Purpose  : Shared types and constants for the UART command decoder: the
//            decoder state type, the ASCII command bytes, time-field limits,
//            the digit count of a set command and a small byte helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SET   = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam int BYTE_W  = 8;
  localparam int DIGIT_W = 4;
  localparam int BIN_W   = 7;

  localparam logic [BYTE_W-1:0] ASCII_R    = 8'h52;
  localparam logic [BYTE_W-1:0] ASCII_C    = 8'h43;
  localparam logic [BYTE_W-1:0] ASCII_M    = 8'h4D;
  localparam logic [BYTE_W-1:0] ASCII_T    = 8'h54;
  localparam logic [BYTE_W-1:0] ASCII_CR   = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF   = 8'h0A;
  localparam logic [BYTE_W-1:0] ASCII_SP   = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_ZERO = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_NINE = 8'h39;

  localparam int HOUR_MAX    = 23;
  localparam int MIN_SEC_MAX = 59;
  localparam int SET_DIGITS  = 6;
  localparam int NUM_FIELDS  = SET_DIGITS / 2;

  // Fold lower-case letters onto upper case so commands compare once.
  function automatic logic [BYTE_W-1:0] to_upper(input logic [BYTE_W-1:0] b);
    logic [BYTE_W-1:0] r;
    r = b;
    if ((b >= 8'h61) && (b <= 8'h7A)) begin
      r = b - 8'h20;
    end
    return r;
  endfunction

  function automatic logic is_digit(input logic [BYTE_W-1:0] b);
    return (b >= ASCII_ZERO) && (b <= ASCII_NINE);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_if.sv
// ============================================================================
// Module   : uart_cmd_if
// Purpose  : First-word-fall-through RX FIFO read port.
// Signals  : rdata - head byte, valid while empty is low
//            empty - FIFO empty flag
//            pop   - consume the head byte this cycle
// Modports : master - FIFO side (drives rdata/empty, reads pop)
//            slave  - consumer side (reads rdata/empty, drives pop)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface uart_cmd_if;
  import uart_cmd_pkg::*;

  logic [BYTE_W-1:0] rdata;
  logic              empty;
  logic              pop;

  modport master (output rdata, output empty, input pop);
  modport slave  (input rdata, input empty, output pop);

endinterface

`default_nettype wire

// File: rtl/uart_cmd_bcd2bin.sv
// ============================================================================
// Module   : uart_cmd_bcd2bin
// Purpose  : Converts a two-digit decimal number (tens, ones) into binary.
//            The result is 7 bits wide so 00..99 is represented exactly.
// Ports    : tens_i [3:0] - tens digit
//            ones_i [3:0] - ones digit
//            bin_o  [6:0] - tens*10 + ones
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_bcd2bin
  import uart_cmd_pkg::*;
(
  input  logic [DIGIT_W-1:0] tens_i,
  input  logic [DIGIT_W-1:0] ones_i,
  output logic [BIN_W-1:0]   bin_o
);

  assign bin_o = ({3'b000, tens_i} * 7'd10) + {3'b000, ones_i};

endmodule

`default_nettype wire

// File: rtl/uart_cmd_decoder.sv
// ============================================================================
// Module   : uart_cmd_decoder
// Purpose  : Decodes ASCII commands from an RX FIFO into stopwatch/watch
//            control pulses and a time-set command "Thhmmss".
// Ports    : clk           - system clock, rising edge
//            rst           - asynchronous active-high reset
//            fifo          - RX FIFO read port (uart_cmd_if.slave)
//            run_toggle_o  - pulse: stopwatch run/stop
//            clear_o       - pulse: stopwatch clear
//            mode_toggle_o - pulse: watch/stopwatch display select
//            set_valid_o   - pulse: set_hour/min/sec newly loaded
//            set_hour_o    - hour 0..23, held
//            set_min_o     - minute 0..59, held
//            set_sec_o     - second 0..59, held
//            err_o         - pulse: rejected byte, value or timeout
//            busy_o        - a set command is in progress
// Config   : define UART_CMD_TIMEOUT_EN to abort a partial set command after
//            TIMEOUT_CYC cycles without a byte.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_cmd_decoder
  import uart_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  uart_cmd_if.slave  fifo,
  output logic       run_toggle_o,
  output logic       clear_o,
  output logic       mode_toggle_o,
  output logic       set_valid_o,
  output logic [4:0] set_hour_o,
  output logic [5:0] set_min_o,
  output logic [5:0] set_sec_o,
  output logic       err_o,
  output logic       busy_o
);

  localparam logic [2:0]       DCNT_LAST   = 3'(SET_DIGITS - 1);
  localparam logic [BIN_W-1:0] HOUR_MAX_B  = 7'(HOUR_MAX);
  localparam logic [BIN_W-1:0] MS_MAX_B    = 7'(MIN_SEC_MAX);

  state_t                          state_q, state_d;
  logic [2:0]                      dcnt_q, dcnt_d;
  logic [SET_DIGITS-1:0][DIGIT_W-1:0] dig_q, dig_d;

  logic run_q, run_d;
  logic clr_q, clr_d;
  logic mode_q, mode_d;
  logic setv_q, setv_d;
  logic err_q, err_d;
  logic [4:0] hour_q, hour_d;
  logic [5:0] min_q, min_d;
  logic [5:0] sec_q, sec_d;

  logic              pop_req;
  logic [BYTE_W-1:0] byte_uc;
  logic              byte_is_digit;
  logic [BIN_W-1:0]  field_bin [NUM_FIELDS];
  logic              fields_ok;

`ifdef UART_CMD_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  // Compared one cycle early so err lands TIMEOUT_CYC cycles after the
  // last consumed byte.
  localparam logic [TMO_W-1:0] TMO_FIRE = TMO_W'(TIMEOUT_CYC - 2);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYC != 0);
`endif

  assign byte_uc       = to_upper(fifo.rdata);
  assign byte_is_digit = is_digit(fifo.rdata);

  // Digit order in dig_q is arrival order: [0]=hour tens ... [5]=sec ones.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    uart_cmd_bcd2bin u_bcd2bin (
      .tens_i (dig_q[2*gi]),
      .ones_i (dig_q[2*gi+1]),
      .bin_o  (field_bin[gi])
    );
  end

  // Limits are checked on the full 7-bit value so e.g. 99 cannot alias into
  // range after truncation.
  assign fields_ok = (field_bin[0] <= HOUR_MAX_B) &&
                     (field_bin[1] <= MS_MAX_B) &&
                     (field_bin[2] <= MS_MAX_B);

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    dig_d   = dig_q;
    hour_d  = hour_q;
    min_d   = min_q;
    sec_d   = sec_q;
    run_d   = 1'b0;
    clr_d   = 1'b0;
    mode_d  = 1'b0;
    setv_d  = 1'b0;
    err_d   = 1'b0;
    pop_req = 1'b0;
`ifdef UART_CMD_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (!fifo.empty) begin
          pop_req = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
          tmo_d   = '0;
`endif
          case (byte_uc)
            ASCII_R: run_d  = 1'b1;
            ASCII_C: clr_d  = 1'b1;
            ASCII_M: mode_d = 1'b1;
            ASCII_T: begin
              state_d = ST_SET;
              dcnt_d  = '0;
              dig_d   = '0;
            end
            ASCII_CR, ASCII_LF, ASCII_SP: begin
            end
            default: err_d = 1'b1;
          endcase
        end
      end

      ST_SET: begin
        if (!fifo.empty) begin
          pop_req = 1'b1;
`ifdef UART_CMD_TIMEOUT_EN
          tmo_d   = '0;
`endif
          if (byte_is_digit) begin
            dig_d[dcnt_q] = fifo.rdata[DIGIT_W-1:0];
            if (dcnt_q == DCNT_LAST) begin
              state_d = ST_CHECK;
              dcnt_d  = '0;
            end else begin
              dcnt_d  = dcnt_q + 3'd1;
            end
          end else begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            dcnt_d  = '0;
            dig_d   = '0;
          end
        end
`ifdef UART_CMD_TIMEOUT_EN
        else if (tmo_q == TMO_FIRE) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          dcnt_d  = '0;
          dig_d   = '0;
          tmo_d   = '0;
        end else begin
          tmo_d   = tmo_q + 1'b1;
        end
`endif
      end

      ST_CHECK: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
        dig_d   = '0;
        if (fields_ok) begin
          hour_d = field_bin[0][4:0];
          min_d  = field_bin[1][5:0];
          sec_d  = field_bin[2][5:0];
          setv_d = 1'b1;
        end else begin
          err_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
        dig_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dcnt_q  <= '0;
      dig_q   <= '0;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      mode_q  <= 1'b0;
      setv_q  <= 1'b0;
      err_q   <= 1'b0;
      hour_q  <= '0;
      min_q   <= '0;
      sec_q   <= '0;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      dig_q   <= dig_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      mode_q  <= mode_d;
      setv_q  <= setv_d;
      err_q   <= err_d;
      hour_q  <= hour_d;
      min_q   <= min_d;
      sec_q   <= sec_d;
`ifdef UART_CMD_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // pop is combinational on the FIFO flag; gating with rst keeps the FIFO
  // from losing a byte that the held-in-reset state never consumes.
  assign fifo.pop      = pop_req & ~rst;

  assign run_toggle_o  = run_q;
  assign clear_o       = clr_q;
  assign mode_toggle_o = mode_q;
  assign set_valid_o   = setv_q;
  assign err_o         = err_q;
  assign set_hour_o    = hour_q;
  assign set_min_o     = min_q;
  assign set_sec_o     = sec_q;
  assign busy_o        = (state_q == ST_SET) || (state_q == ST_CHECK);

endmodule

`default_nettype wire
